// File: rtl/pc_unit_pkg.sv
// Shared architecture constants for the program-counter unit: address map,
// FSM state encoding and pending-redirect kind encoding.
package pc_unit_pkg;

    localparam int          PC_WIDTH_DEF   = 32;
    localparam logic [31:0] IM_ADDR_BASE   = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_OFFSET = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } pc_state_e;

    localparam logic KIND_BR  = 1'b0;
    localparam logic KIND_EXC = 1'b1;

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry pending-redirect buffer. An exception overwrites a branch, a
// newer branch overwrites an older branch, a branch never displaces an exception.
module pc_redirect_buf
    import pc_unit_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_capture,
    input  logic                i_clear,
    input  logic                i_exc_req,
    input  logic                i_br_req,
    input  logic [0:PC_WIDTH-1] i_br_target,
    output logic                o_valid,
    output logic                o_kind,
    output logic [0:PC_WIDTH-1] o_target
);

    logic                r_valid;
    logic                r_kind;
    logic [0:PC_WIDTH-1] r_target;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid  <= 1'b0;
            r_kind   <= KIND_BR;
            r_target <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_capture) begin
            if (i_exc_req) begin
                r_valid <= 1'b1;
                r_kind  <= KIND_EXC;
            end else if (i_br_req && !(r_valid && r_kind == KIND_EXC)) begin
                r_valid  <= 1'b1;
                r_kind   <= KIND_BR;
                r_target <= i_br_target;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_kind   = r_kind;
    assign o_target = r_target;

endmodule

// File: rtl/pc_unit.sv
// Program-counter generator: boot delay, sequential increment, prioritised
// exception/branch redirects and stall buffering. Optional macro PC_ALIGN_CHK_EN.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                  PC_WIDTH   = PC_WIDTH_DEF,
    parameter logic [0:PC_WIDTH-1] RESET_ADDR = PC_WIDTH'(IM_ADDR_BASE),
    parameter int                  INST_BYTES = 4,
    parameter logic [0:PC_WIDTH-1] EXC_VECTOR = PC_WIDTH'(IM_ADDR_BASE + EXC_VEC_OFFSET),
    parameter int                  RESET_WAIT = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_pc_wr,
    input  logic                i_br_req,
    input  logic [0:PC_WIDTH-1] i_br_target,
    input  logic                i_exc_req,
    output logic [0:PC_WIDTH-1] o_pc,
    output logic [0:PC_WIDTH-1] o_npc,
    output logic                o_pc_valid,
    output logic                o_redirected,
`ifdef PC_ALIGN_CHK_EN
    output logic                o_align_err,
`endif
    output logic [1:0]          o_state
);

    // i_pc_wr acts as the downstream ready: the PC advances only on a cycle
    // with i_pc_wr=1; requests seen while it is low are held in the buffer.
    pc_state_e           r_state, w_state_nxt;
    logic [3:0]          r_boot_cnt;
    logic [0:PC_WIDTH-1] r_pc;
    logic                r_pc_valid, r_redirected;
    logic                w_pend_valid, w_pend_kind;
    logic [0:PC_WIDTH-1] w_pend_target;
    logic                w_capture, w_clear, w_load, w_boot_last;
    logic                w_exc_win, w_br_win, w_seq_win, w_misalign;
    logic [0:PC_WIDTH-1] w_pc_seq, w_br_tgt, w_br_load, w_npc;

    pc_redirect_buf #(.PC_WIDTH(PC_WIDTH)) u_redirect_buf (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_capture   (w_capture),
        .i_clear     (w_clear),
        .i_exc_req   (i_exc_req),
        .i_br_req    (i_br_req),
        .i_br_target (i_br_target),
        .o_valid     (w_pend_valid),
        .o_kind      (w_pend_kind),
        .o_target    (w_pend_target)
    );

    assign w_pc_seq  = r_pc + PC_WIDTH'(INST_BYTES);
    assign w_exc_win = i_exc_req || (w_pend_valid && w_pend_kind == KIND_EXC);
    assign w_br_win  = !w_exc_win && (i_br_req || w_pend_valid);
    assign w_seq_win = !w_exc_win && !w_br_win;
    assign w_br_tgt  = i_br_req ? i_br_target : w_pend_target;

`ifdef PC_ALIGN_CHK_EN
    localparam logic [0:PC_WIDTH-1] ALIGN_MASK = PC_WIDTH'(INST_BYTES - 1);
    assign w_misalign = w_br_win && ((w_br_tgt & ALIGN_MASK) != '0);
    assign w_br_load  = w_misalign ? EXC_VECTOR : w_br_tgt;
`else
    assign w_misalign = 1'b0;
    assign w_br_load  = w_br_tgt;
`endif

    assign w_npc = w_exc_win ? EXC_VECTOR : (w_br_win ? w_br_load : w_pc_seq);

    // RESET_WAIT=0 leaves BOOT on the first edge after reset release.
    assign w_boot_last = (RESET_WAIT == 0) || (r_boot_cnt == 4'(RESET_WAIT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_clear     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_capture = 1'b1;
                if (w_boot_last)
                    w_state_nxt = (w_pend_valid || i_exc_req || i_br_req) ? ST_PEND : ST_RUN;
            end
            ST_RUN: begin
                if (i_pc_wr) begin
                    w_load = 1'b1;
                end else begin
                    w_capture = 1'b1;
                    if (i_exc_req || i_br_req)
                        w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (i_pc_wr) begin
                    w_load      = 1'b1;
                    w_clear     = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_capture = 1'b1;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_boot_cnt   <= 4'd0;
            r_pc         <= RESET_ADDR;
            r_pc_valid   <= 1'b0;
            r_redirected <= 1'b0;
        end else begin
            if (r_state == ST_BOOT)
                r_boot_cnt <= r_boot_cnt + 4'd1;
            if (w_load)
                r_pc <= w_npc;
            r_pc_valid   <= r_pc_valid || (w_state_nxt != ST_BOOT);
            r_redirected <= w_load && !w_seq_win;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic r_align_err;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_align_err <= 1'b0;
        else
            r_align_err <= w_load && w_misalign;
    end
    assign o_align_err = r_align_err;
`endif

    assign o_pc         = r_pc;
    assign o_npc        = w_npc;
    assign o_pc_valid   = r_pc_valid;
    assign o_redirected = r_redirected;
    assign o_state      = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random
// traffic, scored against a rule-level model of the PC generator.
module tb_pc_unit;

    localparam int          W     = 32;
    localparam logic [31:0] RST_A = 32'h0000_3000;
    localparam logic [31:0] EXC_V = 32'h0000_3100;
    localparam int          IB    = 4;
    localparam int          RW    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, pc_wr, br_req, exc_req;
    logic [0:W-1] br_target, pc, npc;
    logic         pc_valid, redirected;
    logic [1:0]   dbg_state;
`ifdef PC_ALIGN_CHK_EN
    logic         align_err;
`endif

    pc_unit #(
        .PC_WIDTH   (W),
        .RESET_ADDR (RST_A),
        .INST_BYTES (IB),
        .EXC_VECTOR (EXC_V),
        .RESET_WAIT (RW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pc_wr      (pc_wr),
        .i_br_req     (br_req),
        .i_br_target  (br_target),
        .i_exc_req    (exc_req),
        .o_pc         (pc),
        .o_npc        (npc),
        .o_pc_valid   (pc_valid),
        .o_redirected (redirected),
`ifdef PC_ALIGN_CHK_EN
        .o_align_err  (align_err),
`endif
        .o_state      (dbg_state)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        redir;
        logic        aerr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] npc_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model: booting flag with cycles left, plus one pending entry.
    logic [31:0] m_pc;
    bit          m_valid;
    int          m_boot_left;
    bit          m_ph, m_pe;
    logic [31:0] m_pt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (dut state %0d) at %0t", nm, act, exp, dbg_state, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_A; m_valid = 0; m_boot_left = RW;
        m_ph = 0; m_pe = 0; m_pt = '0;
    endtask

    task automatic model_capture(input bit br, input bit exc, input logic [31:0] tgt);
        if (exc) begin
            m_ph = 1; m_pe = 1;
        end else if (br && !(m_ph && m_pe)) begin
            m_ph = 1; m_pe = 0; m_pt = tgt;
        end
    endtask

    task automatic model_step(input bit wr, input bit br, input bit exc, input logic [31:0] tgt,
                              output logic [31:0] n, output exp_t e);
        bit          exc_win, br_win, mis;
        logic [31:0] bt;
        exc_win = exc || (m_ph && m_pe);
        br_win  = !exc_win && (br || m_ph);
        bt      = br ? tgt : m_pt;
        mis     = 0;
`ifdef PC_ALIGN_CHK_EN
        if (br_win && (bt % IB) != 0) begin
            mis = 1; bt = EXC_V;
        end
`endif
        n = exc_win ? EXC_V : (br_win ? bt : m_pc + IB);
        e.redir = 0;
        e.aerr  = 0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_valid) begin
            model_capture(br, exc, tgt);
            m_valid = (m_boot_left <= 1);
            m_boot_left--;
        end else if (wr) begin
            m_pc    = n;
            e.redir = exc_win || br_win;
            e.aerr  = mis;
            m_ph    = 0;
        end else begin
            model_capture(br, exc, tgt);
        end
        e.pc    = m_pc;
        e.valid = m_valid;
    endtask

    task automatic cyc(input bit wr, input bit br, input logic [31:0] tgt, input bit exc);
        logic [31:0] n;
        exp_t        e;
        @(negedge clk);
        pc_wr = wr; br_req = br; br_target = tgt; exc_req = exc;
        model_step(wr, br, exc, tgt, n, e);
        npc_q.push_back(n);
        exp_q.push_back(e);
    endtask

    // Reset asserted between edges; outputs must follow without a clock.
    task automatic async_reset(input int hold);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_pc", pc, RST_A);
        chk("async_rst_valid", pc_valid, 1'b0);
        chk("async_rst_redir", redirected, 1'b0);
        repeat (hold) cyc(1, 0, '0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("pc", pc, mon_e.pc);
            chk("pc_valid", pc_valid, mon_e.valid);
            chk("redirected", redirected, mon_e.redir);
`ifdef PC_ALIGN_CHK_EN
            chk("align_err", align_err, mon_e.aerr);
`endif
        end
    end

    always @(negedge clk) begin
        #2;
        if (npc_q.size() > 0)
            chk("npc", npc, npc_q.pop_front());
    end

    initial begin
        rst_n = 1'b0; pc_wr = 0; br_req = 0; br_target = '0; exc_req = 0;
        model_reset();
        repeat (2) cyc(1, 0, '0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Boot delay then sequential fetch up to 0x3010.
        repeat (6) cyc(1, 0, '0, 0);
        // Direct branch then sequential.
        cyc(1, 1, 32'h3400, 0);
        cyc(1, 0, '0, 0);
        // Stalled branch followed by exception: exception wins on release.
        cyc(1, 1, 32'h3020, 0);
        cyc(0, 1, 32'h3500, 0);
        cyc(0, 0, '0, 0);
        cyc(0, 0, '0, 1);
        cyc(1, 0, '0, 0);
        // Pending branch overridden by a fresh branch in the release cycle.
        cyc(0, 1, 32'h3600, 0);
        cyc(1, 1, 32'h3700, 0);
        cyc(1, 0, '0, 0);
        // Simultaneous requests: exception wins.
        cyc(1, 1, 32'h3800, 1);
        // Wrap at the top of the address space.
        cyc(1, 1, 32'hFFFF_FFFC, 0);
        cyc(1, 0, '0, 0);
        cyc(1, 0, '0, 0);
        // Reset while a redirect is pending.
        cyc(0, 1, 32'h3900, 0);
        async_reset(2);
        repeat (4) cyc(1, 0, '0, 0);
        // Misaligned branch target.
        cyc(1, 1, 32'h3402, 0);
        cyc(1, 0, '0, 0);
        // Requests during boot are buffered.
        async_reset(1);
        cyc(1, 1, 32'h3A00, 0);
        cyc(1, 0, '0, 0);
        cyc(1, 0, '0, 0);
        cyc(1, 0, '0, 0);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] t;
            bit          wr, br, ex;
            wr = ($urandom_range(0, 9) < 7);
            br = ($urandom_range(0, 9) < 2);
            ex = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
            else
                t = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0)
                t = t | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 149) == 0)
                async_reset($urandom_range(1, 3));
            cyc(wr, br, t, ex);
        end

        repeat (3) @(negedge clk);
        chk("queue_drain", 32'(exp_q.size() + npc_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
